seq_detect_param: RTL and testbench

Parametrised serial pattern detector, the general successor to the fixed 1011 detector. It samples one bit per qualified clock and flags every completion of a runtime-programmable pattern of 1 to MAX_LEN bits. Overlapping or non-overlapping matching is selectable, and a saturating match counter is included. It sits between a serial bit source and the control/status logic that consumes match events.

---
 rtl/seq_detect_param.sv | 132 +++++++++++++
 tb/tb_seq_detect_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial pattern detector with a runtime-programmable pattern of 1..MAX_LEN
// bits. One bit is sampled per clock when in_valid is high. Every completion
// of the pattern raises seq_seen for one cycle and bumps a saturating counter.
// Overlapping or non-overlapping matching is selected by the latched config.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   inp_bit     serial data bit
//   in_valid    inp_bit is sampled only when high
//   cfg_load    strobe: latch pattern/pat_len/overlap_en, clear history
//   pattern     pattern bits, [pat_len-1] arrives first, [0] arrives last
//   pat_len     requested pattern length (0 disables, >MAX_LEN clamps)
//   overlap_en  1 = overlapping matches, 0 = history restarts after a match
//   count_clr   clears match_count (wins over a same-cycle increment)
//   seq_seen    registered one-cycle match pulse
//   match_count saturating number of matches
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > MAX_L) ? MAX_L : l;
  endfunction

  logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_ovl_q, cfg_ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               seq_seen_q, seq_seen_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;

  logic [LEN_W-1:0]   len_eff;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] win_mask;
  logic               hit;

  always_comb begin
    cfg_pat_d     = cfg_pat_q;
    cfg_len_d     = cfg_len_q;
    cfg_ovl_d     = cfg_ovl_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    match_count_d = match_count_q;

    len_eff  = clamp_len(cfg_len_q);
    hist_nxt = {hist_q[MAX_LEN-2:0], inp_bit};
    fill_nxt = (fill_q >= MAX_L) ? MAX_L : fill_q + 1'b1;

    // Only the newest len_eff history bits take part in the compare.
    win_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      win_mask[i] = (LEN_W'(i) < len_eff);
    end

    // A bit arriving alongside cfg_load is discarded, so it cannot match.
    hit = in_valid && !cfg_load && (len_eff != '0) && (fill_nxt >= len_eff) &&
          (((hist_nxt ^ cfg_pat_q) & win_mask) == '0);

    seq_seen_d = hit;

    if (cfg_load) begin
      cfg_pat_d = pattern;
      cfg_len_d = pat_len;
      cfg_ovl_d = overlap_en;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = hist_nxt;
      // Non-overlapping mode keeps the shifted history but forgets how many
      // bits are valid, so the next match needs a full fresh window.
      fill_d = (hit && !cfg_ovl_q) ? '0 : fill_nxt;
    end

    if (count_clr) begin
      match_count_d = '0;
    end else if (hit) begin
      match_count_d = sat_inc(match_count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_pat_q     <= RST_PATTERN;
      cfg_len_q     <= LEN_W'(RST_LEN);
      cfg_ovl_q     <= RST_OVERLAP;
      hist_q        <= '0;
      fill_q        <= '0;
      seq_seen_q    <= 1'b0;
      match_count_q <= '0;
    end else begin
      cfg_pat_q     <= cfg_pat_d;
      cfg_len_q     <= cfg_len_d;
      cfg_ovl_q     <= cfg_ovl_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      seq_seen_q    <= seq_seen_d;
      match_count_q <= match_count_d;
    end
  end

  assign seq_seen    = seq_seen_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default-sized instance for pattern
// behaviour, plus a CNT_W=2 instance for counter saturation and clear.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  // Main instance (CNT_W = 8)
  logic       a_bit = 1'b0, a_vld = 1'b0, a_load = 1'b0, a_ovl = 1'b1, a_clr = 1'b0;
  logic [7:0] a_pat = 8'b0000_1011;
  logic [3:0] a_len = 4'd4;
  logic       a_seen;
  logic [7:0] a_cnt;

  // Narrow-counter instance (CNT_W = 2)
  logic       b_bit = 1'b0, b_vld = 1'b0, b_load = 1'b0, b_ovl = 1'b1, b_clr = 1'b0;
  logic [7:0] b_pat = 8'b0000_0001;
  logic [3:0] b_len = 4'd1;
  logic       b_seen;
  logic [1:0] b_cnt;

  int checks = 0;
  int failures = 0;

  seq_detect_param dut_a (
    .clk(clk), .reset(reset), .inp_bit(a_bit), .in_valid(a_vld),
    .cfg_load(a_load), .pattern(a_pat), .pat_len(a_len), .overlap_en(a_ovl),
    .count_clr(a_clr), .seq_seen(a_seen), .match_count(a_cnt)
  );

  seq_detect_param #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .inp_bit(b_bit), .in_valid(b_vld),
    .cfg_load(b_load), .pattern(b_pat), .pat_len(b_len), .overlap_en(b_ovl),
    .count_clr(b_clr), .seq_seen(b_seen), .match_count(b_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle on instance A, then observe just after the edge.
  task automatic step_a(input logic b, input logic v);
    a_bit = b; a_vld = v;
    @(posedge clk); #1;
    a_vld = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] p, input logic [3:0] l, input logic o);
    a_pat = p; a_len = l; a_ovl = o; a_load = 1'b1;
    a_bit = 1'b1; a_vld = 1'b1;  // this bit must be discarded
    @(posedge clk); #1;
    a_load = 1'b0; a_vld = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (a_seen !== 1'b0) begin failures++; $display("FAIL reset_seen got=%b exp=0", a_seen); end
    checks++;
    if (a_cnt !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    checks++;
    if (b_cnt !== 2'd0) begin failures++; $display("FAIL reset_count_b got=%0d exp=0", b_cnt); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      step_a(bits[i], 1'b1);
      checks++;
      if (a_seen !== exp[i]) begin
        failures++; $display("FAIL overlap_bit%0d got=%b exp=%b", 7 - i, a_seen, exp[i]);
      end
    end
    checks++;
    if (a_cnt !== 8'd2) begin failures++; $display("FAIL overlap_count got=%0d exp=2", a_cnt); end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001000;
    load_a(8'b0000_1011, 4'd4, 1'b0);
    checks++;
    if (a_seen !== 1'b0) begin failures++; $display("FAIL load_seen got=%b exp=0", a_seen); end
    for (int i = 6; i >= 0; i--) begin
      step_a(bits[i], 1'b1);
      checks++;
      if (a_seen !== exp[i]) begin
        failures++; $display("FAIL nonovl_bit%0d got=%b exp=%b", 7 - i, a_seen, exp[i]);
      end
    end
    checks++;
    if (a_cnt !== 8'd3) begin failures++; $display("FAIL nonovl_count got=%0d exp=3", a_cnt); end
  endtask

  task automatic test_restart();
    logic [4:0] s1 = 5'b11011;
    logic [4:0] e1 = 5'b00001;
    logic [5:0] s2 = 6'b101011;
    logic [5:0] e2 = 6'b000001;
    load_a(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      step_a(s1[i], 1'b1);
      checks++;
      if (a_seen !== e1[i]) begin
        failures++; $display("FAIL restart1_bit%0d got=%b exp=%b", 5 - i, a_seen, e1[i]);
      end
    end
    load_a(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      step_a(s2[i], 1'b1);
      checks++;
      if (a_seen !== e2[i]) begin
        failures++; $display("FAIL restart2_bit%0d got=%b exp=%b", 6 - i, a_seen, e2[i]);
      end
    end
    checks++;
    if (a_cnt !== 8'd5) begin failures++; $display("FAIL restart_count got=%0d exp=5", a_cnt); end
  endtask

  task automatic test_gapped_long();
    logic [7:0] p = 8'b1110_0101;
    load_a(p, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step_a(p[i], 1'b1);
      checks++;
      if (a_seen !== (i == 0)) begin
        failures++; $display("FAIL gapped_bit%0d got=%b exp=%b", 8 - i, a_seen, (i == 0));
      end
      step_a(1'b0, 1'b0);
      checks++;
      if (a_seen !== 1'b0) begin
        failures++; $display("FAIL gapped_idle%0d got=%b exp=0", 8 - i, a_seen);
      end
    end
    checks++;
    if (a_cnt !== 8'd6) begin failures++; $display("FAIL gapped_count got=%0d exp=6", a_cnt); end
  endtask

  task automatic test_len_zero();
    logic seen_any = 1'b0;
    load_a(8'b0000_0000, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step_a(i[0], 1'b1);
      seen_any = seen_any | a_seen;
    end
    checks++;
    if (seen_any !== 1'b0) begin failures++; $display("FAIL len0_seen got=%b exp=0", seen_any); end
    checks++;
    if (a_cnt !== 8'd6) begin failures++; $display("FAIL len0_count got=%0d exp=6", a_cnt); end
  endtask

  task automatic test_len_clamp();
    logic [7:0] p = 8'b1110_0101;
    load_a(p, 4'd12, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step_a(p[i], 1'b1);
      checks++;
      if (a_seen !== (i == 0)) begin
        failures++; $display("FAIL clamp_bit%0d got=%b exp=%b", 8 - i, a_seen, (i == 0));
      end
    end
    checks++;
    if (a_cnt !== 8'd7) begin failures++; $display("FAIL clamp_count got=%0d exp=7", a_cnt); end
  endtask

  task automatic test_reset_mid();
    load_a(8'b0000_1011, 4'd4, 1'b1);
    step_a(1'b1, 1'b1);
    step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (a_cnt !== 8'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", a_cnt); end
    @(posedge clk); #1;
    reset = 1'b1;
    step_a(1'b1, 1'b1);
    checks++;
    if (a_seen !== 1'b0) begin failures++; $display("FAIL midreset_stale got=%b exp=0", a_seen); end
    step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    checks++;
    if (a_seen !== 1'b0) begin failures++; $display("FAIL midreset_early got=%b exp=0", a_seen); end
    step_a(1'b1, 1'b1);
    checks++;
    if (a_seen !== 1'b1) begin failures++; $display("FAIL midreset_fresh got=%b exp=1", a_seen); end
    checks++;
    if (a_cnt !== 8'd1) begin failures++; $display("FAIL midreset_cnt got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b_pat = 8'b0000_0001; b_len = 4'd1; b_ovl = 1'b1; b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_bit = 1'b1; b_vld = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (b_seen !== 1'b1) begin failures++; $display("FAIL sat_seen%0d got=%b exp=1", i, b_seen); end
      checks++;
      if (b_cnt !== exp_cnt[i]) begin
        failures++; $display("FAIL sat_count%0d got=%0d exp=%0d", i, b_cnt, exp_cnt[i]);
      end
    end
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    checks++;
    if (b_seen !== 1'b1) begin failures++; $display("FAIL clr_seen got=%b exp=1", b_seen); end
    checks++;
    if (b_cnt !== 2'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", b_cnt); end
    @(posedge clk); #1;
    b_vld = 1'b0;
    checks++;
    if (b_cnt !== 2'd1) begin failures++; $display("FAIL after_clr_count got=%0d exp=1", b_cnt); end
    @(posedge clk); #1;
    checks++;
    if (b_seen !== 1'b0) begin failures++; $display("FAIL idle_seen_b got=%b exp=0", b_seen); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_restart();
    test_gapped_long();
    test_len_zero();
    test_len_clamp();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
